// File: rtl/mem_arbiter_if.sv
// Requester request/response channels plus memory-macro pins shared by mem_arbiter.
// slave modport: the arbiter side. master modport: clients and memory macro side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;

    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;

    logic                  rsp0_valid;
    logic                  rsp0_ready;
    logic [DATA_WIDTH-1:0] rsp0_rdata;

    logic                  rsp1_valid;
    logic                  rsp1_ready;
    logic [DATA_WIDTH-1:0] rsp1_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  rsp0_ready, rsp1_ready, mem_rdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output mem_addr, mem_wr_en, mem_rd_en, mem_wdata, busy
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output rsp0_ready, rsp1_ready, mem_rdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  mem_addr, mem_wr_en, mem_rd_en, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory (1-cycle read).
// One transaction in flight: IDLE -> ISSUE -> (write) IDLE | (read) CAPTURE -> RESP -> IDLE.
// Optional macro MEM_ARB_FIXED_PRIO_EN: requester 0 always wins contention
// (default build: round-robin, requester 0 wins the first contention after reset).
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e                state_q,      state_d;
    logic                  grant_q,      grant_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
    logic                  mem_wr_en_q,  mem_wr_en_d;
    logic                  mem_rd_en_q,  mem_rd_en_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;
    logic                  busy_q,       busy_d;

    logic                  win1_c;
    logic                  req_we_c;
    logic                  req0_ready_c;
    logic                  req1_ready_c;

    // grant_q doubles as last_grant for round-robin and as response routing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wr_en_q  <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_rd_en_q  <= mem_rd_en_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
            busy_q       <= busy_d;
        end
    end

    // Arbitration winner: 1 means requester 1 gets the grant this cycle
    always_comb begin
        win1_c = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        win1_c = bus.req1_valid && !bus.req0_valid;
`else
        win1_c = bus.req1_valid && (!bus.req0_valid || !grant_q);
`endif
    end

    // Next-state, memory pin and response decode
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wr_en_d  = 1'b0;
        mem_rd_en_d  = 1'b0;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        req_we_c     = 1'b0;
        req0_ready_c = 1'b0;
        req1_ready_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    req0_ready_c = !win1_c;
                    req1_ready_c = win1_c;
                    req_we_c     = win1_c ? bus.req1_we : bus.req0_we;
                    grant_d      = win1_c;
                    mem_addr_d   = win1_c ? bus.req1_addr  : bus.req0_addr;
                    mem_wdata_d  = win1_c ? bus.req1_wdata : bus.req0_wdata;
                    mem_wr_en_d  = req_we_c;
                    mem_rd_en_d  = !req_we_c;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // The memory acts on the edge closing this cycle
                state_d = mem_wr_en_q ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                if (grant_q) begin
                    rsp1_rdata_d = bus.mem_rdata;
                    rsp1_valid_d = 1'b1;
                end else begin
                    rsp0_rdata_d = bus.mem_rdata;
                    rsp0_valid_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                // The memory stays blocked until the response is taken
                if (grant_q ? bus.rsp1_ready : bus.rsp0_ready) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.req0_ready = req0_ready_c;
    assign bus.req1_ready = req1_ready_c;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wr_en  = mem_wr_en_q;
    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then random traffic,
// checked by a negedge monitor against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;
    localparam int DEPTH = 8;
    localparam int BOUND = 200;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory macro: fills with 0xFF on reset, registered read
    logic [DW-1:0] mem_array [DEPTH];
    logic [DW-1:0] mem_rdata_q;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_array[i] <= 8'hFF;
            mem_rdata_q <= 8'hFF;
        end else begin
            if (bus.mem_wr_en) mem_array[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_rd_en) mem_rdata_q <= mem_array[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mem_rdata_q;

    // Reference model state (transaction level)
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic          ref_last;
`endif
    logic          outstanding;
    logic          pend;
    logic          pend_we;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    int            acc_cyc [2];
    logic          prev_v [2];
    logic [DW-1:0] held [2];
    logic          rnd_on;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;
        exp_q0.delete();
        exp_q1.delete();
`ifndef MEM_ARB_FIXED_PRIO_EN
        ref_last = 1'b1;
`endif
        outstanding = 1'b0;
        pend        = 1'b0;
        prev_v[0]   = 1'b0;
        prev_v[1]   = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                         bus.rsp0_rdata, bus.rsp1_rdata, bus.mem_addr, bus.mem_wr_en,
                         bus.mem_rd_en, bus.mem_wdata, bus.busy}), 64'd0);
    endtask

    // Per-cycle monitor: arbitration, memory pins, busy and response scoreboard
    task automatic monitor_step();
        logic v0, v1, r0, r1, exp_w, we, rv, rr;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rd, expd;
        int hn;
        v0 = bus.req0_valid; v1 = bus.req1_valid;
        r0 = bus.req0_ready; r1 = bus.req1_ready;

        check("busy", 64'(bus.busy), 64'(outstanding));
        if (outstanding) begin
            check("ready_while_busy", 64'({r1, r0}), 64'd0);
        end else if (v0 || v1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_w = !v0;
`else
            exp_w = (v0 && v1) ? !ref_last : !v0;
`endif
            check("grant", 64'({r1, r0}), exp_w ? 64'd2 : 64'd1);
        end else begin
            check("ready_no_req", 64'({r1, r0}), 64'd0);
        end

        if (pend) begin
            check("mem_wr_en", 64'(bus.mem_wr_en), 64'(pend_we));
            check("mem_rd_en", 64'(bus.mem_rd_en), 64'(!pend_we));
            check("mem_addr", 64'(bus.mem_addr), 64'(pend_addr));
            if (pend_we) begin
                check("mem_wdata", 64'(bus.mem_wdata), 64'(pend_data));
                outstanding = 1'b0;
            end
            pend = 1'b0;
        end else begin
            check("mem_en_quiet", 64'({bus.mem_wr_en, bus.mem_rd_en}), 64'd0);
        end

        for (int n = 0; n < 2; n++) begin
            if (n == 0) begin
                rv = bus.rsp0_valid; rr = bus.rsp0_ready; rd = bus.rsp0_rdata;
            end else begin
                rv = bus.rsp1_valid; rr = bus.rsp1_ready; rd = bus.rsp1_rdata;
            end
            if (rv) begin
                if (!prev_v[n]) begin
                    check($sformatf("rsp%0d_latency", n), 64'(cyc - acc_cyc[n]), 64'd3);
                    held[n] = rd;
                end else begin
                    check($sformatf("rsp%0d_stable", n), 64'(rd), 64'(held[n]));
                end
                if (rr) begin
                    if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
                        fail($sformatf("rsp%0d_unexpected", n), $sformatf("rdata %0h with no read pending", rd));
                    end else begin
                        expd = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("rsp%0d_rdata", n), 64'(rd), 64'(expd));
                    end
                    outstanding = 1'b0;
                end
            end
            prev_v[n] = rv && !rr;
        end

        if ((v0 && r0) || (v1 && r1)) begin
            hn = (v1 && r1) ? 1 : 0;
            we = hn ? bus.req1_we : bus.req0_we;
            a  = hn ? bus.req1_addr : bus.req0_addr;
            d  = hn ? bus.req1_wdata : bus.req0_wdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ref_last = 1'(hn);
`endif
            outstanding = 1'b1;
            pend        = 1'b1;
            pend_we     = we;
            pend_addr   = a;
            pend_data   = d;
            if (we) ref_mem[a] = d;
            else if (hn == 0) exp_q0.push_back(ref_mem[a]);
            else exp_q1.push_back(ref_mem[a]);
            acc_cyc[hn] = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) monitor_step();
    end

    task automatic set_req(input int n, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    function automatic logic handshake_of(input int n);
        return (n == 0) ? (bus.req0_valid && bus.req0_ready) : (bus.req1_valid && bus.req1_ready);
    endfunction

    task automatic wait_accept(input int n);
        logic ok = 1'b0;
        for (int i = 0; i < BOUND && !ok; i++) begin
            @(negedge clk);
            if (handshake_of(n)) ok = 1'b1;
        end
        if (!ok) fail($sformatf("req%0d_accept", n), "ready stayed 0, required 1 within bound");
        @(posedge clk); #1;
        set_req(n, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_req(input int n, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_req(n, 1'b1, we, a, d);
        wait_accept(n);
    endtask

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int i = 0; i < BOUND && !ok; i++) begin
            @(negedge clk); #1;
            if (!outstanding) ok = 1'b1;
        end
        if (!ok) fail("drain", "transaction still outstanding at bound");
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp0();
        logic ok = 1'b0;
        for (int i = 0; i < BOUND && !ok; i++) begin
            @(negedge clk);
            if (bus.rsp0_valid) ok = 1'b1;
        end
        if (!ok) fail("rsp0_wait", "rsp0_valid stayed 0, required 1 within bound");
    endtask

    task automatic driver(input int n, input int count);
        for (int k = 0; k < count; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            set_req(n, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                    DW'($urandom_range(0, 255)));
            wait_accept(n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        rnd_on = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset_values");
        @(posedge clk); #1;
        reset = 1'b0;

        // Read before any write returns the memory fill value
        do_req(0, 1'b0, 3'd3, 8'h00);
        wait_idle();

        // Write then read back through requester 1
        do_req(1, 1'b1, 3'd5, 8'hA5);
        wait_idle();
        do_req(1, 1'b0, 3'd5, 8'h00);
        wait_idle();

        // Back-to-back writes accepted every 2 cycles
        do_req(0, 1'b1, 3'd6, 8'h11);
        t0 = cyc;
        do_req(0, 1'b1, 3'd7, 8'h22);
        t1 = cyc;
        check("b2b_write_spacing", 64'(t1 - t0), 64'd2);
        wait_idle();

        // Repeated contention on writes to 0/1
        for (int r = 0; r < 4; r++) begin
            set_req(0, 1'b1, 1'b1, 3'd0, 8'(r));
            set_req(1, 1'b1, 1'b1, 3'd1, 8'(r + 16));
            fork
                wait_accept(0);
                wait_accept(1);
            join
        end
        wait_idle();

        // Response held off: memory stays blocked, requester 1 waits
        bus.rsp0_ready = 1'b0;
        do_req(0, 1'b0, 3'd5, 8'h00);
        set_req(1, 1'b1, 1'b1, 3'd4, 8'h5A);
        wait_rsp0();
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp0_valid", 64'(bus.rsp0_valid), 64'd1);
            check("hold_req1_ready", 64'(bus.req1_ready), 64'd0);
            check("hold_busy", 64'(bus.busy), 64'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("req1_after_rsp0", 64'(bus.req1_ready), 64'd1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, '0, '0);
        wait_idle();

        // Reset during ISSUE of a write: the write must not land
        do_req(0, 1'b1, 3'd2, 8'h3C);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check_all_zero("reset_in_issue");
        model_reset();
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_req(0, 1'b0, 3'd2, 8'h00);
        wait_idle();

        // Reset while a response is pending
        bus.rsp0_ready = 1'b0;
        do_req(0, 1'b0, 3'd1, 8'h00);
        wait_rsp0();
        #1;
        reset = 1'b1;
        #1;
        check("rsp0_drop_on_reset", 64'(bus.rsp0_valid), 64'd0);
        check_all_zero("reset_in_resp");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.rsp0_ready = 1'b1;
        set_req(1, 1'b1, 1'b0, 3'd1, 8'h00);
        @(negedge clk);
        check("idle_after_reset", 64'(bus.req1_ready), 64'd1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, '0, '0);
        wait_idle();

        // Random traffic from both requesters with random response back-pressure
        rnd_on = 1'b1;
        fork
            begin
                fork
                    driver(0, 30);
                    driver(1, 30);
                join
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    bus.rsp0_ready = 1'($urandom_range(0, 1));
                    bus.rsp1_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        wait_idle();
        if (exp_q0.size() != 0 || exp_q1.size() != 0)
            fail("leftover_rsp", $sformatf("%0d/%0d responses never delivered", exp_q0.size(), exp_q1.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
